// File: rtl/arc4_pkg.sv
// Shared RC4 definitions: used by the key scheduler and by the PRGA decryptor.
package arc4_pkg;

  localparam int         DATA_W       = 8;
  localparam logic [7:0] MSG_LEN_ADDR = 8'd0;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    LEN_W,
    I_RD,
    J_RD,
    SW_I,
    SW_J,
    PAD_RD,
    XOR_WR
  } prga_state_t;

endpackage

// File: rtl/prga_if.sv
// Start handshake plus the S-array, ciphertext and plaintext memory ports of the PRGA.
interface prga_if;
  import arc4_pkg::*;

  logic              en;
  logic              rdy;
  logic [DATA_W-1:0] s_addr;
  logic [DATA_W-1:0] s_rddata;
  logic [DATA_W-1:0] s_wrdata;
  logic              s_wren;
  logic [DATA_W-1:0] ct_addr;
  logic [DATA_W-1:0] ct_rddata;
  logic [DATA_W-1:0] pt_addr;
  logic [DATA_W-1:0] pt_wrdata;
  logic              pt_wren;

  // The PRGA drives the memories, so it is the master side of this bundle.
  modport master (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

endinterface

// File: rtl/prga.sv
// RC4 pseudo-random generation: decrypts a length-prefixed message using a pre-scheduled S array.
module prga
  import arc4_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  prga_if.master bus
);

  prga_state_t       state, state_n;
  logic [DATA_W-1:0] i, j, k, len, si, sj;
  logic [DATA_W-1:0] j_sum;

  logic              rdy;
  logic [DATA_W-1:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
  logic              s_wren, pt_wren;

  assign j_sum = j + bus.s_rddata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Memory-facing outputs depend only on state, datapath registers and the one-cycle read data.
  always_comb begin
    state_n   = state;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.en) state_n = LEN;
      end
      LEN: begin
        ct_addr = MSG_LEN_ADDR;
        state_n = LEN_W;
      end
      LEN_W: begin
        pt_addr   = MSG_LEN_ADDR;
        pt_wrdata = bus.ct_rddata;
        pt_wren   = 1'b1;
        state_n   = (bus.ct_rddata == '0) ? IDLE : I_RD;
      end
      I_RD: begin
        s_addr  = i;
        state_n = J_RD;
      end
      J_RD: begin
        s_addr  = j_sum;
        state_n = SW_I;
      end
      SW_I: begin
        s_addr   = i;
        s_wrdata = bus.s_rddata;
        s_wren   = 1'b1;
        state_n  = SW_J;
      end
      SW_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        state_n  = PAD_RD;
      end
      PAD_RD: begin
        s_addr  = si + sj;
        ct_addr = k;
        state_n = XOR_WR;
      end
      XOR_WR: begin
        pt_addr   = k;
        pt_wrdata = bus.s_rddata ^ bus.ct_rddata;
        pt_wren   = 1'b1;
        state_n   = (k == len) ? IDLE : I_RD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: si and sj are latched so the pad address survives the i==j swap unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      len <= '0;
      si  <= '0;
      sj  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        LEN_W: begin
          len <= bus.ct_rddata;
          k   <= 8'd1;
          i   <= 8'd1;
        end
        J_RD: begin
          si <= bus.s_rddata;
          j  <= j_sum;
        end
        SW_I: sj <= bus.s_rddata;
        XOR_WR: begin
          if (k != len) begin
            k <= k + 8'd1;
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rdy       = rdy;
  assign bus.s_addr    = s_addr;
  assign bus.s_wrdata  = s_wrdata;
  assign bus.s_wren    = s_wren;
  assign bus.ct_addr   = ct_addr;
  assign bus.pt_addr   = pt_addr;
  assign bus.pt_wrdata = pt_wrdata;
  assign bus.pt_wren   = pt_wren;

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: behavioural RC4 model, synchronous memory models, randomized messages.
module tb_prga;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;

  prga_if bus();

  prga dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] s_rd;
  logic [7:0] ct_rd;
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;
  int         tests = 0;
  int         failures = 0;
  int         m_s    [256];
  int         exp_pt [256];

  logic [7:0] kat_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] kat_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] key    [3]  = '{8'h4B, 8'h65, 8'h79};

  assign bus.s_rddata  = s_rd;
  assign bus.ct_rddata = ct_rd;

  // Synchronous memories with one-cycle read latency; load refreshes S and poisons PT.
  always @(posedge clk) begin
    if (load) begin
      for (int n = 0; n < 256; n++) begin
        s_mem[n]  <= s_init[n];
        pt_mem[n] <= 8'hEE;
      end
    end else begin
      if (bus.s_wren) begin
        s_mem[bus.s_addr] <= bus.s_wrdata;
        s_wr_cnt <= s_wr_cnt + 1;
      end
      if (bus.pt_wren) begin
        pt_mem[bus.pt_addr] <= bus.pt_wrdata;
        pt_wr_cnt <= pt_wr_cnt + 1;
      end
    end
    s_rd  <= s_mem[bus.s_addr];
    ct_rd <= ct_mem[bus.ct_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Straight RC4 PRGA on integer arrays, starting from s_init and ct_mem.
  task automatic modelRun();
    int i = 0;
    int j = 0;
    int si, sj, len;
    for (int n = 0; n < 256; n++) m_s[n] = int'(s_init[n]);
    len = int'(ct_mem[0]);
    exp_pt[0] = len;
    for (int kk = 1; kk <= len; kk++) begin
      i = (i + 1) % 256;
      si = m_s[i];
      j = (j + si) % 256;
      sj = m_s[j];
      m_s[i] = sj;
      m_s[j] = si;
      exp_pt[kk] = int'(ct_mem[kk]) ^ m_s[(si + sj) % 256];
    end
  endtask

  task automatic loadMemories();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic setIdentity();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
  endtask

  task automatic setShuffled();
    logic [7:0] t;
    int r;
    setIdentity();
    for (int n = 255; n > 0; n--) begin
      r = int'($urandom_range(n, 0));
      t = s_init[n];
      s_init[n] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic setKsa();
    logic [7:0] t;
    int j = 0;
    setIdentity();
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(s_init[n]) + int'(key[n % 3])) % 256;
      t = s_init[n];
      s_init[n] = s_init[j];
      s_init[j] = t;
    end
  endtask

  task automatic setRandomCt(input int len);
    ct_mem[0] = 8'(len);
    for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom);
  endtask

  // Starts one run and counts rising edges from the accepting edge until rdy returns.
  task automatic applyStimulus(input bit pulse_en, input int abort_at, output int cycles);
    int wait_n = 0;
    @(negedge clk);
    while (!bus.rdy && wait_n < 2000) begin
      @(negedge clk);
      wait_n++;
    end
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    cycles = 0;
    while (cycles < 2000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (abort_at != 0 && cycles == abort_at) begin
        rst_n = 1'b0;
        break;
      end
      if (bus.rdy) break;
      bus.en = pulse_en && (cycles % 4 == 1);
    end
    bus.en = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input bit pulse_en);
    int cycles, s0, p0, len, idx;
    modelRun();
    loadMemories();
    s0  = s_wr_cnt;
    p0  = pt_wr_cnt;
    len = int'(ct_mem[0]);
    applyStimulus(pulse_en, 0, cycles);
    @(negedge clk);
    checkOutput({name, "/latency"}, cycles, 6 * len + 2);
    checkOutput({name, "/s_writes"}, s_wr_cnt - s0, 2 * len);
    checkOutput({name, "/pt_writes"}, pt_wr_cnt - p0, len + 1);
    for (int kk = 0; kk <= len; kk++)
      checkOutput($sformatf("%s/pt[%0d]", name, kk), pt_mem[kk], exp_pt[kk]);
    idx = 0;
    for (int n = 0; n < 256; n++) begin
      if (s_mem[n] !== 8'(m_s[n])) begin
        idx = n;
        break;
      end
    end
    checkOutput($sformatf("%s/s_final[%0d]", name, idx), s_mem[idx], m_s[idx]);
  endtask

  initial begin
    int cycles, s0, p0;
    bus.en = 1'b0;
    for (int n = 0; n < 256; n++) ct_mem[n] = 8'h00;
    setIdentity();
    repeat (2) @(negedge clk);
    checkOutput("reset/rdy", bus.rdy, 1);
    checkOutput("reset/wren", {bus.s_wren, bus.pt_wren}, 0);
    checkOutput("reset/addr", {bus.s_addr, bus.ct_addr, bus.pt_addr}, 0);
    checkOutput("reset/wrdata", {bus.s_wrdata, bus.pt_wrdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity S, single byte: i==j swap at index 1, pad = S[2].
    setIdentity();
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h00;
    runAndCheck("ident", 1'b0);
    checkOutput("ident/pt1_known", pt_mem[1], 8'h02);
    checkOutput("ident/s1_known", s_mem[1], 8'h01);

    setIdentity();
    ct_mem[0] = 8'h00;
    runAndCheck("len0", 1'b0);

    // Classic key "Key" / "Plaintext" vector.
    setKsa();
    for (int n = 0; n < 10; n++) ct_mem[n] = kat_ct[n];
    runAndCheck("kat", 1'b0);
    for (int n = 1; n < 10; n++)
      checkOutput($sformatf("kat/known[%0d]", n), pt_mem[n], kat_pt[n]);

    setIdentity();
    setRandomCt(255);
    runAndCheck("len255", 1'b0);

    for (int r = 0; r < 6; r++) begin
      setShuffled();
      setRandomCt(int'($urandom_range(24, 1)));
      runAndCheck($sformatf("rand%0d", r), r[0]);
    end

    // Abort during SW_J of byte 3 (17 edges after acceptance).
    setIdentity();
    setRandomCt(5);
    loadMemories();
    s0 = s_wr_cnt;
    p0 = pt_wr_cnt;
    applyStimulus(1'b0, 17, cycles);
    #1;
    checkOutput("abort/rdy", bus.rdy, 1);
    checkOutput("abort/wren", {bus.s_wren, bus.pt_wren}, 0);
    checkOutput("abort/addr", {bus.s_addr, bus.ct_addr, bus.pt_addr}, 0);
    checkOutput("abort/wrdata", {bus.s_wrdata, bus.pt_wrdata}, 0);
    checkOutput("abort/s_writes_before", s_wr_cnt - s0, 5);
    checkOutput("abort/pt_writes_before", pt_wr_cnt - p0, 3);
    s0 = s_wr_cnt;
    p0 = pt_wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("abort/s_writes_after", s_wr_cnt - s0, 0);
    checkOutput("abort/pt_writes_after", pt_wr_cnt - p0, 0);
    checkOutput("abort/rdy_after", bus.rdy, 1);

    setIdentity();
    setRandomCt(7);
    runAndCheck("rerun", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
